// File: rtl/div_ctrl_16b_pkg.sv
// Shared types and sizing for the SAYAC restoring-divider sequencer.
package div_ctrl_16b_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_ctrl_16b_iter_cnt.sv
// Iteration counter for the divider: clear has priority over enable, tc marks the last iteration.
module div_iter_cnt #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/div_ctrl_16b.sv
// Sequencing FSM for the SAYAC multi-cycle restoring divider: one iteration is SHIFT then SUB.
module div_ctrl_16b
    import div_ctrl_16b_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic flush_i,
    input  logic div_zero_i,
    input  logic diff_neg_i,
    output logic ready_o,
    output logic busy_o,
    output logic done_o,
    output logic dz_err_o,
    output logic rem_init_o,
    output logic rem_ld_o,
    output logic rem_sh_o,
    output logic q_ld_o,
    output logic q_sh_o,
    output logic q_set0_o
);

    div_state_e state_q, state_d, fsm_nxt_s;
    logic       dz_q, dz_d;
    logic       tc_s, cnt_clr_s, cnt_en_s;
    logic       ready_s, busy_s, done_s, dz_err_s;
    logic       rem_init_s, rem_ld_s, rem_sh_s, q_ld_s, q_sh_s, q_set0_s;

    div_iter_cnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr_s | flush_i),
        .en_i   (cnt_en_s & ~flush_i),
        .tc_o   (tc_s)
    );

    // state decode: next state and Moore strobes before flush override
    always_comb begin
        fsm_nxt_s  = state_q;
        dz_d       = dz_q;
        ready_s    = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        dz_err_s   = 1'b0;
        rem_init_s = 1'b0;
        rem_ld_s   = 1'b0;
        rem_sh_s   = 1'b0;
        q_ld_s     = 1'b0;
        q_sh_s     = 1'b0;
        q_set0_s   = 1'b0;
        cnt_clr_s  = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_s = 1'b1;
                if (start_i && !flush_i) begin
                    fsm_nxt_s = S_LOAD;
                    dz_d      = div_zero_i;
                end else begin
                    fsm_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                busy_s     = 1'b1;
                rem_init_s = 1'b1;
                q_ld_s     = 1'b1;
                cnt_clr_s  = 1'b1;
                fsm_nxt_s  = dz_q ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                // remainder takes the old quotient MSB as both shift together
                busy_s    = 1'b1;
                rem_sh_s  = 1'b1;
                q_sh_s    = 1'b1;
                fsm_nxt_s = S_SUB;
            end
            S_SUB: begin
                busy_s = 1'b1;
                if (!diff_neg_i) begin
                    rem_ld_s = 1'b1;
                    q_set0_s = 1'b1;
                end else begin
                    rem_ld_s = 1'b0;
                    q_set0_s = 1'b0;
                end
                if (tc_s) begin
                    fsm_nxt_s = S_DONE;
                end else begin
                    cnt_en_s  = 1'b1;
                    fsm_nxt_s = S_SHIFT;
                end
            end
            S_DONE: begin
                done_s    = 1'b1;
                dz_err_s  = dz_q;
                fsm_nxt_s = S_IDLE;
            end
            default: begin
                fsm_nxt_s = S_IDLE;
            end
        endcase
    end

    // flush aborts to IDLE, clears the remainder and masks all other datapath strobes
    assign state_d    = flush_i ? S_IDLE : fsm_nxt_s;
    assign rem_init_o = rem_init_s | flush_i;
    assign rem_ld_o   = rem_ld_s & ~flush_i;
    assign rem_sh_o   = rem_sh_s & ~flush_i;
    assign q_ld_o     = q_ld_s & ~flush_i;
    assign q_sh_o     = q_sh_s & ~flush_i;
    assign q_set0_o   = q_set0_s & ~flush_i;
    assign ready_o    = ready_s;
    assign busy_o     = busy_s;
    assign done_o     = done_s;
    assign dz_err_o   = dz_err_s;

    // state and divide-by-zero flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl_16b.sv
// Directed bench: controller driving a behavioural restoring-divider datapath, hand-computed results.
module tb_div_ctrl_16b;

    logic clk_i = 1'b0;
    logic rst_ni, start_i, flush_i, div_zero_i, diff_neg_i;
    logic ready_o, busy_o, done_o, dz_err_o;
    logic rem_init_o, rem_ld_o, rem_sh_o, q_ld_o, q_sh_o, q_set0_o;

    logic [15:0] dvd, dvs, q_r;
    logic [16:0] rem_r, diff_s;
    int vectors = 0;
    int miscompares = 0;
    int sh_seen, done_seen, ready_low_ok, cyc;
    logic prev_done = 1'b0;

    always #5 clk_i = ~clk_i;

    div_ctrl_16b dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .flush_i(flush_i),
        .div_zero_i(div_zero_i), .diff_neg_i(diff_neg_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .dz_err_o(dz_err_o),
        .rem_init_o(rem_init_o), .rem_ld_o(rem_ld_o), .rem_sh_o(rem_sh_o),
        .q_ld_o(q_ld_o), .q_sh_o(q_sh_o), .q_set0_o(q_set0_o)
    );

    // datapath: 17b remainder shift reg, 16b quotient shift reg, subtractor
    assign diff_s     = rem_r - {1'b0, dvs};
    assign diff_neg_i = diff_s[16];

    always_ff @(posedge clk_i) begin
        if (rem_init_o)   rem_r <= 17'd0;
        else if (rem_ld_o) rem_r <= diff_s;
        else if (rem_sh_o) rem_r <= {rem_r[15:0], q_r[15]};
        else               rem_r <= rem_r;
        if (q_ld_o)        q_r <= dvd;
        else if (q_sh_o)   q_r <= {q_r[14:0], 1'b0};
        else if (q_set0_o) q_r <= {q_r[15:1], 1'b1};
        else               q_r <= q_r;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        check("rem_strobe_excl", {31'd0, $onehot0({rem_init_o, rem_ld_o, rem_sh_o})}, 32'd1);
        check("q_strobe_excl", {31'd0, $onehot0({q_ld_o, q_sh_o, q_set0_o})}, 32'd1);
        check("busy_vs_ready_done", {31'd0, busy_o}, {31'd0, ~(ready_o | done_o)});
        check("done_width", {31'd0, done_o & prev_done}, 32'd0);
        prev_done = done_o;
        if (rem_sh_o || q_sh_o) sh_seen++;
        if (done_o) done_seen++;
    endtask

    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input int rs_lo, input int rs_hi);
        dvd = a; dvs = b; div_zero_i = (b == 16'd0);
        sh_seen = 0; done_seen = 0; ready_low_ok = 1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        cyc = 1;
        while (!done_o && cyc < 100) begin
            if (ready_o) ready_low_ok = 0;
            start_i = (cyc >= rs_lo && cyc <= rs_hi);
            step();
            cyc++;
        end
        if (ready_o) ready_low_ok = 0;
        start_i = 1'b0;
    endtask

    task automatic post(input string tag, input int exp_cyc, input logic [15:0] eq,
                        input logic [15:0] er, input logic edz);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_quot"}, {16'd0, q_r}, {16'd0, eq});
        check({tag, "_rem"}, {15'd0, rem_r}, {16'd0, er});
        check({tag, "_dz_err"}, {31'd0, dz_err_o}, {31'd0, edz});
        check({tag, "_ready_low"}, 32'(ready_low_ok), 32'd1);
        step();
        check({tag, "_ready_after"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0; div_zero_i = 1'b0;
        dvd = 16'd0; dvs = 16'd1;
        #3;
        check("reset_outs", {22'd0, ready_o, busy_o, done_o, dz_err_o, rem_init_o, rem_ld_o,
                             rem_sh_o, q_ld_o, q_sh_o, q_set0_o}, 32'h200);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        step();

        run_div(16'd100, 16'd7, 1000, 0);
        post("d100_7", 34, 16'd14, 16'd2, 1'b0);
        run_div(16'hFFFF, 16'd1, 1000, 0);
        post("dffff_1", 34, 16'hFFFF, 16'd0, 1'b0);
        run_div(16'd5, 16'd9, 1000, 0);
        post("d5_9", 34, 16'd0, 16'd5, 1'b0);
        run_div(16'hFFFF, 16'hFFFF, 1000, 0);
        post("dffff_ffff", 34, 16'd1, 16'd0, 1'b0);

        run_div(16'd1234, 16'd0, 1000, 0);
        post("dz", 2, 16'd1234, 16'd0, 1'b1);
        check("dz_no_shift", 32'(sh_seen), 32'd0);

        run_div(16'd100, 16'd7, 5, 20);
        post("restart_ign", 34, 16'd14, 16'd2, 1'b0);
        step();
        step();
        check("restart_single_done", 32'(done_seen), 32'd1);
        check("restart_idle", {31'd0, ready_o}, 32'd1);
        run_div(16'd100, 16'd7, 1000, 0);
        post("back2back", 34, 16'd14, 16'd2, 1'b0);

        // abort in the SUB cycle of the fifth iteration (cycle 11)
        dvd = 16'd100; dvs = 16'd7; div_zero_i = 1'b0; done_seen = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        cyc = 1;
        while (cyc < 11) begin
            step();
            cyc++;
        end
        check("flush_in_sub", {29'd0, rem_sh_o, q_sh_o, busy_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush_strobes", {26'd0, rem_init_o, rem_ld_o, rem_sh_o, q_ld_o, q_sh_o, q_set0_o},
              32'h20);
        step();
        flush_i = 1'b0;
        #1;
        check("flush_to_idle", {30'd0, ready_o, busy_o}, 32'd2);
        step();
        step();
        step();
        check("flush_no_done", 32'(done_seen), 32'd0);
        run_div(16'd50, 16'd5, 1000, 0);
        post("after_flush", 34, 16'd10, 16'd0, 1'b0);

        // asynchronous reset while in SHIFT (cycle 4)
        dvd = 16'd100; dvs = 16'd7;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        step();
        check("in_shift", {30'd0, rem_sh_o, q_sh_o}, 32'd3);
        rst_ni = 1'b0;
        #1;
        check("async_rst_outs", {22'd0, ready_o, busy_o, done_o, dz_err_o, rem_init_o, rem_ld_o,
                                 rem_sh_o, q_ld_o, q_sh_o, q_set0_o}, 32'h200);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        prev_done = 1'b0;
        step();
        check("rst_idle", {31'd0, ready_o}, 32'd1);
        run_div(16'd100, 16'd7, 1000, 0);
        post("after_rst", 34, 16'd14, 16'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
